// File: rtl/uart_frame_parser.sv
// Delineates HEADER/CMD/LEN/PAYLOAD/CHK frames from a UART byte stream, checks the additive checksum, replays good payloads.
// Latency: frame_ok and the first out_valid appear one cycle after the checksum strobe; one payload byte per accepted handshake.
// Backpressure: out_ready stalls the replay indefinitely (no timeout while stalled); bytes arriving during replay are dropped with a pulse.
module uart_frame_parser #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 104_166
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  output logic [7:0] cmd,
  output logic [7:0] len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       drop
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int MEM_D = 1 << IDX_W;

  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_OUT
  } state_t;

  state_t           state_q,     state_d;
  logic [7:0]       cmd_sh_q,    cmd_sh_d;
  logic [7:0]       len_sh_q,    len_sh_d;
  logic [7:0]       sum_q,       sum_d;
  logic [IDX_W-1:0] wr_idx_q,    wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q,    rd_idx_d;
  logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
  logic [7:0]       cmd_q,       cmd_d;
  logic [7:0]       len_q,       len_d;
  logic             frame_ok_q,  frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q,  err_code_d;
  logic [7:0]       out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic             drop_q,      drop_d;

  // Payload store; sized to the full index range so any index value is in bounds.
  logic [7:0]       pay_mem [MEM_D];
  logic             buf_we;
  logic [IDX_W-1:0] buf_waddr;
  logic [7:0]       buf_wdata;
  logic [IDX_W-1:0] rd_nxt;

  assign rd_nxt = rd_idx_q + 1'b1;

  // Next-state logic: byte-driven framing, inter-byte timeout and payload replay.
  always_comb begin
    state_d     = state_q;
    cmd_sh_d    = cmd_sh_q;
    len_sh_d    = len_sh_q;
    sum_d       = sum_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    to_cnt_d    = to_cnt_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    drop_d      = 1'b0;
    buf_we      = 1'b0;
    buf_waddr   = wr_idx_q;
    buf_wdata   = rx_data;

    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (rx_flag && (rx_data == HEADER)) begin
          state_d = S_CMD;
        end
      end

      S_OUT: begin
        // Counter stays frozen so a stalled consumer never causes a timeout.
        to_cnt_d = '0;
        if (rx_flag) begin
          drop_d = 1'b1;
        end
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rd_idx_d    = '0;
          end else begin
            rd_idx_d   = rd_nxt;
            out_data_d = pay_mem[rd_nxt];
            out_last_d = (8'(rd_nxt) == (len_sh_q - 8'd1));
          end
        end
      end

      default: begin
        // Frame-collection states: a consumed byte always beats an expiring timeout.
        if (rx_flag) begin
          to_cnt_d = '0;
          case (state_q)
            S_CMD: begin
              cmd_sh_d = rx_data;
              sum_d    = rx_data;
              state_d  = S_LEN;
            end
            S_LEN: begin
              if (rx_data > MAX_LEN_B) begin
                frame_err_d = 1'b1;
                err_code_d  = ERR_LEN;
                state_d     = S_IDLE;
              end else if (rx_data == 8'd0) begin
                len_sh_d = 8'd0;
                state_d  = S_CHK;
              end else begin
                len_sh_d = rx_data;
                sum_d    = sum_q + rx_data;
                wr_idx_d = '0;
                state_d  = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              buf_we   = 1'b1;
              sum_d    = sum_q + rx_data;
              wr_idx_d = wr_idx_q + 1'b1;
              if (8'(wr_idx_q) == (len_sh_q - 8'd1)) begin
                state_d = S_CHK;
              end
            end
            S_CHK: begin
              if (rx_data == sum_q) begin
                frame_ok_d = 1'b1;
                cmd_d      = cmd_sh_q;
                len_d      = len_sh_q;
                if (len_sh_q != 8'd0) begin
                  state_d     = S_OUT;
                  rd_idx_d    = '0;
                  out_valid_d = 1'b1;
                  out_data_d  = pay_mem[IDX_ZERO];
                  out_last_d  = (len_sh_q == 8'd1);
                end else begin
                  state_d = S_IDLE;
                end
              end else begin
                frame_err_d = 1'b1;
                err_code_d  = ERR_CHK;
                state_d     = S_IDLE;
              end
            end
            default: ;
          endcase
        end else if (to_cnt_q == TO_LAST) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TO;
          to_cnt_d    = '0;
          state_d     = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State and registered outputs; reset abandons any partial frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_sh_q    <= '0;
      len_sh_q    <= '0;
      sum_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      to_cnt_q    <= '0;
      cmd_q       <= '0;
      len_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_sh_q    <= cmd_sh_d;
      len_sh_q    <= len_sh_d;
      sum_q       <= sum_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      to_cnt_q    <= to_cnt_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      drop_q      <= drop_d;
    end
  end

  // Payload write port; contents are only read after being written for the current frame, so no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      pay_mem[buf_waddr] <= buf_wdata;
    end
  end

  assign cmd       = cmd_q;
  assign len       = len_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed frames plus randomized frames against a frame-level reference.
// Expected outcomes come from checksum/length arithmetic on each generated frame.
// Consumer readiness is always-on, held off, or random depending on the test phase.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TO      = 40;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_flag   = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] cmd, len, out_data;
  logic       frame_ok, frame_err, out_valid, out_last, drop;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .HEADER      (8'hA5),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_flag   (rx_flag),
    .cmd       (cmd),
    .len       (len),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .drop      (drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: event counters and received payload stream, sampled on the falling edge.
  int         cyc = 0, ok_cnt = 0, err_cnt = 0, drop_cnt = 0;
  logic [1:0] last_code = 2'b00;
  logic [7:0] rx_q[$];
  logic       last_q[$];
  int         hs_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (frame_ok) ok_cnt++;
      if (frame_err) begin
        err_cnt++;
        last_code = err_code;
      end
      if (frame_ok || frame_err) check("ok_err_excl", 32'(frame_ok & frame_err), 0);
      if (out_valid && out_ready) begin
        rx_q.push_back(out_data);
        last_q.push_back(out_last);
        hs_cyc.push_back(cyc);
      end
      if (drop) drop_cnt++;
    end
  end

  // Consumer readiness: 0 = always ready, 1 = stalled, 2 = random.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [7:0] exp_cmd = 8'h00;
  logic [7:0] exp_len = 8'h00;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_flag = 1'b1;
    tick(1);
    rx_flag = 1'b0;
  endtask

  function automatic logic [7:0] csum(input logic [7:0] c, input logic [7:0] l, input logic [7:0] pl[$]);
    logic [7:0] s;
    s = c + l;
    foreach (pl[i]) s = s + pl[i];
    return s;
  endfunction

  task automatic send_body(input logic [7:0] c, input logic [7:0] l, input logic [7:0] pl[$], input int gap);
    send_byte(8'hA5);
    tick($urandom_range(0, gap));
    send_byte(c);
    tick($urandom_range(0, gap));
    send_byte(l);
    foreach (pl[i]) begin
      tick($urandom_range(0, gap));
      send_byte(pl[i]);
    end
    tick($urandom_range(0, gap));
  endtask

  task automatic wait_drain(input int base, input int n);
    int k = 0;
    while (((rx_q.size() < base + n) || out_valid) && (k < 2000)) begin
      tick(1);
      k++;
    end
    check("drain_count", 32'(rx_q.size() - base), 32'(n));
  endtask

  task automatic check_payload(input int base, input logic [7:0] pl[$]);
    if (rx_q.size() >= base + pl.size()) begin
      foreach (pl[i]) begin
        check("pay_data", rx_q[base + i], pl[i]);
        check("pay_last", 32'(last_q[base + i]), 32'(i == pl.size() - 1));
      end
    end
  endtask

  task automatic run_good(input logic [7:0] c, input logic [7:0] pl[$], input int gap);
    int base, ok0, err0;
    logic [7:0] l;
    base = rx_q.size();
    ok0  = ok_cnt;
    err0 = err_cnt;
    l    = 8'(pl.size());
    send_body(c, l, pl, gap);
    send_byte(csum(c, l, pl));
    check("ok_pulse", 32'(frame_ok), 1);
    check("valid_with_ok", 32'(out_valid), 32'(l != 0));
    if (l != 0) wait_drain(base, int'(l));
    tick(3);
    exp_cmd = c;
    exp_len = l;
    check("ok_count", 32'(ok_cnt - ok0), 1);
    check("err_count_good", 32'(err_cnt - err0), 0);
    check("cmd_out", cmd, exp_cmd);
    check("len_out", len, exp_len);
    check("pay_count", 32'(rx_q.size() - base), 32'(l));
    check_payload(base, pl);
  endtask

  task automatic run_bad_chk(input logic [7:0] c, input logic [7:0] pl[$], input logic [7:0] chk_b, input int gap);
    int base, ok0, err0;
    base = rx_q.size();
    ok0  = ok_cnt;
    err0 = err_cnt;
    send_body(c, 8'(pl.size()), pl, gap);
    send_byte(chk_b);
    check("bad_chk_valid", 32'(out_valid), 0);
    tick(3);
    check("bad_chk_err", 32'(err_cnt - err0), 1);
    check("bad_chk_code", last_code, 2'b10);
    check("bad_chk_ok", 32'(ok_cnt - ok0), 0);
    check("bad_chk_bytes", 32'(rx_q.size() - base), 0);
    check("bad_chk_cmd", cmd, exp_cmd);
    check("bad_chk_len", len, exp_len);
  endtask

  task automatic run_len_err(input logic [7:0] c, input logic [7:0] l);
    int ok0, err0;
    ok0  = ok_cnt;
    err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(c);
    send_byte(l);
    tick(3);
    check("len_err_count", 32'(err_cnt - err0), 1);
    check("len_err_code", last_code, 2'b01);
    check("len_err_code_held", err_code, 2'b01);
    check("len_err_ok", 32'(ok_cnt - ok0), 0);
  endtask

  function automatic logic [7:0] non_header();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hA5) b = 8'h5A;
    return b;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] pl[$];
    int base, ok0, err0, d0;

    // Reset values.
    tick(3);
    check("rst_cmd", cmd, 0);
    check("rst_len", len, 0);
    check("rst_ok", 32'(frame_ok), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_code", err_code, 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_drop", 32'(drop), 0);
    rst_n = 1'b1;
    rdy_mode = 0;
    tick(3);

    // Good frame, consumer always ready: bytes on consecutive cycles.
    base = rx_q.size();
    pl = '{8'h11, 8'h22, 8'h33};
    run_good(8'h10, pl, 0);
    check("csum_example", csum(8'h10, 8'h03, pl), 8'h79);
    if (hs_cyc.size() >= base + 3) begin
      check("back_to_back_1", 32'(hs_cyc[base + 1] - hs_cyc[base]), 1);
      check("back_to_back_2", 32'(hs_cyc[base + 2] - hs_cyc[base + 1]), 1);
    end

    // Zero-length frame.
    pl = {};
    run_good(8'h20, pl, 0);

    // Length error, including the first illegal length, then recovery.
    run_len_err(8'h01, 8'h11);
    run_len_err(8'h02, 8'(MAX_LEN + 1));
    pl = '{8'h44};
    run_good(8'h10, pl, 1);

    // Bad checksum keeps previous cmd/len.
    pl = '{8'h01, 8'h02};
    run_bad_chk(8'h10, pl, 8'h00, 0);

    // Timeout after the expiry cycle.
    err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h10);
    tick(TO - 1);
    check("to_not_yet", 32'(frame_err), 0);
    tick(1);
    check("to_pulse", 32'(frame_err), 1);
    check("to_code", err_code, 2'b11);
    tick(2);
    check("to_count", 32'(err_cnt - err0), 1);

    // A byte on the expiry cycle wins.
    err0 = err_cnt;
    ok0  = ok_cnt;
    base = rx_q.size();
    send_byte(8'hA5);
    send_byte(8'h10);
    tick(TO - 1);
    send_byte(8'h02);
    check("to_win_no_err", 32'(frame_err), 0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h15);
    wait_drain(base, 2);
    tick(2);
    check("to_win_err_count", 32'(err_cnt - err0), 0);
    check("to_win_ok_count", 32'(ok_cnt - ok0), 1);
    pl = '{8'h01, 8'h02};
    check_payload(base, pl);
    exp_cmd = 8'h10;
    exp_len = 8'h02;

    // Backpressure and drop during replay.
    rdy_mode = 1;
    tick(1);
    err0 = err_cnt;
    d0   = drop_cnt;
    base = rx_q.size();
    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_body(8'h30, 8'h03, pl, 0);
    send_byte(csum(8'h30, 8'h03, pl));
    tick(3 * TO);
    check("stall_valid", 32'(out_valid), 1);
    check("stall_data", out_data, 8'hAA);
    check("stall_last", 32'(out_last), 0);
    check("stall_no_to", 32'(err_cnt - err0), 0);
    send_byte(8'hA5);
    check("drop_pulse", 32'(drop), 1);
    check("drop_data_hold", out_data, 8'hAA);
    rdy_mode = 0;
    wait_drain(base, 3);
    tick(2);
    check_payload(base, pl);
    check("drop_count", 32'(drop_cnt - d0), 1);
    check("bp_idle_valid", 32'(out_valid), 0);
    exp_cmd = 8'h30;
    exp_len = 8'h03;

    // Reset mid-frame: no error pulse, outputs back to zero.
    err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'h01);
    rst_n = 1'b0;
    tick(1);
    check("midrst_cmd", cmd, 0);
    check("midrst_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    tick(2);
    check("midrst_no_err", 32'(err_cnt - err0), 0);
    exp_cmd = 8'h00;
    exp_len = 8'h00;

    // Full-length frame.
    pl = {};
    for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom_range(0, 255)));
    run_good(8'h7E, pl, 2);

    // Randomized frames with random consumer readiness and idle-line garbage.
    rdy_mode = 2;
    for (int f = 0; f < 30; f++) begin
      int kind, n, ng;
      logic [7:0] c;
      ng = $urandom_range(0, 3);
      for (int g = 0; g < ng; g++) begin
        send_byte(non_header());
        tick($urandom_range(0, 3));
      end
      kind = $urandom_range(0, 9);
      c    = 8'($urandom_range(0, 255));
      pl   = {};
      if (kind <= 5) begin
        n = $urandom_range(0, MAX_LEN);
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
        run_good(c, pl, 5);
      end else if (kind <= 8) begin
        n = $urandom_range(1, MAX_LEN);
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
        run_bad_chk(c, pl, csum(c, 8'(n), pl) + 8'($urandom_range(1, 255)), 5);
      end else begin
        run_len_err(c, 8'($urandom_range(MAX_LEN + 1, 255)));
      end
    end

    rdy_mode = 0;
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Sits directly downstream of the UART byte receiver. It consumes the receiver's 8-bit data and one-cycle data-valid strobe, and delineates framed commands of the form HEADER, CMD, LEN, PAYLOAD[LEN], CHK. Each payload is buffered internally, the 8-bit additive checksum is verified, and a good payload is replayed to the application over a valid/ready stream. Bad frames are reported with a pulse and an error code.

Parameters:
HEADER, 8'hA5, start-of-frame byte.
MAX_LEN, 16, maximum payload length in bytes (1..255).
TIMEOUT_CYC, 104_166, inter-byte timeout in clk cycles (two byte times at 9600 baud, 50 MHz).

Ports:
clk  in  1  system clock
rst_n  in  1  reset
rx_data  in  8  received byte from the UART receiver
rx_flag  in  1  one-cycle strobe; rx_data is valid while it is high
cmd  out  8  command byte of the last good frame
len  out  8  payload length of the last good frame
frame_ok  out  1  one-cycle pulse: frame passed its checksum
frame_err  out  1  one-cycle pulse: frame aborted
err_code  out  2  01=length>MAX_LEN, 10=checksum, 11=timeout; held until the next error
out_data  out  8  payload byte
out_valid  out  1  payload byte available
out_last  out  1  qualifies the final payload byte
out_ready  in  1  consumer accepts out_data when out_valid && out_ready
drop  out  1  one-cycle pulse: a byte arrived during OUT and was discarded

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE. All outputs are 0, err_code=00, and the buffer index and timeout counter are 0.
- Reset mid-frame: any in-progress frame is discarded with no error pulse.
- Checksum: 8-bit modulo-256 sum of CMD, LEN and all payload bytes. HEADER is excluded.
- Only cycles with rx_flag=1 consume a byte. rx_data is ignored otherwise.
- IDLE: byte==HEADER -> CMD. Any other byte is ignored silently.
- CMD: store the byte in a cmd shadow register, sum=byte -> LEN.
- LEN:
  - byte>MAX_LEN: frame_err=1, err_code=01 -> IDLE.
  - byte==0: -> CHK.
  - Otherwise: store len shadow, sum+=byte, wr_idx=0 -> PAYLOAD.
- PAYLOAD: buf[wr_idx]=byte, sum+=byte, wr_idx++. When the byte written is at index len-1 -> CHK.
- CHK:
  - byte==sum: frame_ok pulses the cycle after the rx_flag. In the same cycle cmd/len outputs update from the shadows. Then -> OUT if len>0, else -> IDLE.
  - byte!=sum: frame_err=1, err_code=10 -> IDLE. cmd/len outputs stay unchanged.
- OUT:
  - out_valid=1 and out_data=buf[rd_idx], starting with rd_idx=0.
  - out_last=1 when rd_idx==len-1.
  - On handshake rd_idx++. The handshake on the last byte -> IDLE, and out_valid drops the following cycle.
  - out_data, out_last and out_valid stay stable while out_ready=0.
  - Any rx_flag in OUT pulses drop. The byte is discarded, including HEADER.
- Timeout:
  - Active in CMD, LEN, PAYLOAD and CHK. The counter resets to 0 on every consumed byte and on entering IDLE, and increments otherwise.
  - Counter reaching TIMEOUT_CYC-1: frame_err=1, err_code=11 -> IDLE.
  - If rx_flag arrives in the expiry cycle, the byte wins: it is processed and the counter clears. No timeout occurs.
  - The counter is frozen at 0 in IDLE and OUT, so there is no timeout while the consumer stalls.
- Latency: frame_ok is 1 cycle after the checksum strobe. The first out_valid is asserted together with frame_ok.
- Errors: frame_ok and frame_err never pulse in the same cycle.
- Width: the buffer index is $clog2(MAX_LEN) bits wide. len compares are done at 8 bits.

Test Plan:
- Good frame: A5 10 03 11 22 33 79 with out_ready=1 -> frame_ok=1 once, cmd=10, len=03. Stream 11,22,33 on consecutive cycles, out_last only on 33, frame_err never set.
- Zero length: A5 20 00 20 -> frame_ok, cmd=20, len=00, out_valid never asserted, state returns to IDLE.
- Length error: A5 01 11 -> frame_err with err_code=01. Next A5 10 01 44 55 -> frame_ok, out_data=44.
- Bad checksum: A5 10 02 01 02 00 -> frame_err, err_code=10, no out_valid, cmd/len keep their previous values.
- Timeout: A5 10, then idle for TIMEOUT_CYC cycles -> frame_err, err_code=11. A byte landing exactly on the expiry cycle -> no error.
- Backpressure and drop: good 3-byte frame, out_ready=0 for 50 cycles -> out_data holds the first byte. Send A5 during the stall -> drop pulse. Release out_ready -> all 3 bytes delivered in order, then IDLE.
